// File: rtl/sat_loader_pkg.sv
// Shared types and helpers for the clause array loader: FSM states, literal codes
// and the saturating literal-count function.
package sat_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RD_ISSUE,
    ST_RD_HOLD,
    ST_DONE
  } state_e;

  localparam logic [1:0] LIT_NONE = 2'b00;
  localparam logic [1:0] LIT_POS  = 2'b01;
  localparam logic [1:0] LIT_NEG  = 2'b10;
  localparam logic [1:0] LIT_BAD  = 2'b11;

  // Clamp a literal count to the largest value a w-bit length field can hold.
  function automatic int unsigned sat_count(input int unsigned n, input int unsigned w);
    int unsigned lim;
    lim = (32'd1 << w) - 32'd1;
    return (n > lim) ? lim : n;
  endfunction

endpackage

// File: rtl/clause_bin_loader_if.sv
// Bus bundle between the loader, its input/output streams and the clause array rows.
// master: the loader; slave: the stream source/sink and the array.
interface clause_bin_loader_if #(
  parameter int unsigned NUM_VARS    = 8,
  parameter int unsigned NUM_CLAUSES = 8,
  parameter int unsigned WIDTH_C_LEN = 4
);
  logic                               in_valid_i;
  logic                               in_ready_o;
  logic [NUM_VARS*2-1:0]              in_clause_i;
  logic [NUM_CLAUSES-1:0]             wr_o;
  logic [NUM_CLAUSES-1:0]             rd_o;
  logic [NUM_VARS*2-1:0]              clause_o;
  logic [WIDTH_C_LEN-1:0]             clause_len_o;
  logic [NUM_VARS*2-1:0]              clause_i;
  logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] clause_len_i;
  logic                               out_valid_o;
  logic                               out_ready_i;
  logic [NUM_VARS*2-1:0]              out_clause_o;
  logic [WIDTH_C_LEN-1:0]             out_len_o;

  modport master (
    input  in_valid_i, in_clause_i, clause_i, clause_len_i, out_ready_i,
    output in_ready_o, wr_o, rd_o, clause_o, clause_len_o, out_valid_o, out_clause_o, out_len_o
  );

  modport slave (
    output in_valid_i, in_clause_i, clause_i, clause_len_i, out_ready_i,
    input  in_ready_o, wr_o, rd_o, clause_o, clause_len_o, out_valid_o, out_clause_o, out_len_o
  );
endinterface

// File: rtl/lit_counter.sv
// Combinational literal count over NUM_VARS 2-bit fields, saturated to WIDTH_C_LEN bits,
// plus the illegal-code / empty / saturated flags used by the beat checker.
module lit_counter
  import sat_loader_pkg::*;
#(
  parameter int unsigned NUM_VARS    = 8,
  parameter int unsigned WIDTH_C_LEN = 4
) (
  input  logic [NUM_VARS*2-1:0]  clause,
  output logic [WIDTH_C_LEN-1:0] len_c,
  output logic                   bad_c,
  output logic                   zero_c,
  output logic                   sat_c
);
  int unsigned n;

  always_comb begin
    n     = 0;
    bad_c = 1'b0;
    for (int i = 0; i < int'(NUM_VARS); i++) begin
      if (clause[2*i +: 2] != LIT_NONE) n = n + 1;
      if (clause[2*i +: 2] == LIT_BAD)  bad_c = 1'b1;
    end
    len_c  = WIDTH_C_LEN'(sat_count(n, WIDTH_C_LEN));
    zero_c = (n == 0);
    sat_c  = (n > sat_count(n, WIDTH_C_LEN));
  end
endmodule

// File: rtl/clause_bin_loader.sv
// Load/readback sequencer for the clause array rows.
// Optional beat checker (sticky err_o) enabled by `define CLAUSE_BIN_LOADER_CHECK_EN.
module clause_bin_loader
  import sat_loader_pkg::*;
#(
  parameter int unsigned NUM_VARS    = 8,
  parameter int unsigned NUM_CLAUSES = 8,
  parameter int unsigned WIDTH_C_LEN = 4,
  parameter int unsigned WIDTH_IDX   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_load_i,
  input  logic                 start_rd_i,
  input  logic [WIDTH_IDX-1:0] num_clauses_i,
  clause_bin_loader_if.master  bus,
  output logic                 busy_o,
  output logic                 done_o
`ifdef CLAUSE_BIN_LOADER_CHECK_EN
  ,
  output logic                 err_o
`endif
);
  localparam int unsigned CW = NUM_VARS * 2;
  localparam logic [WIDTH_IDX-1:0] MAX_CNT = WIDTH_IDX'(NUM_CLAUSES);

  state_e                 state, state_nxt;
  logic [WIDTH_IDX-1:0]   idx, idx_nxt, cnt, cnt_nxt;
  logic [NUM_CLAUSES-1:0] wr_q, wr_nxt;
  logic [CW-1:0]          clause_q, clause_nxt, out_clause_q, out_clause_nxt;
  logic [WIDTH_C_LEN-1:0] len_q, len_nxt, out_len_q, out_len_nxt;
  logic [WIDTH_C_LEN-1:0] lit_len_c, row_len_c;
  logic                   out_valid_q, out_valid_nxt, busy_q, done_q;
  logic                   accept_c, is_last_c, lit_bad_c, lit_zero_c, lit_sat_c;

  lit_counter #(.NUM_VARS(NUM_VARS), .WIDTH_C_LEN(WIDTH_C_LEN)) u_lit (
    .clause (bus.in_clause_i),
    .len_c  (lit_len_c),
    .bad_c  (lit_bad_c),
    .zero_c (lit_zero_c),
    .sat_c  (lit_sat_c)
  );

  assign accept_c = (state == ST_LOAD) && (cnt != '0) && bus.in_valid_i;
  assign is_last_c = (idx == cnt - WIDTH_IDX'(1));

  // Length slice of the currently selected row.
  always_comb begin
    row_len_c = '0;
    for (int r = 0; r < int'(NUM_CLAUSES); r++) begin
      if (idx == WIDTH_IDX'(r)) row_len_c = bus.clause_len_i[r*WIDTH_C_LEN +: WIDTH_C_LEN];
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    cnt_nxt        = cnt;
    wr_nxt         = '0;
    clause_nxt     = clause_q;
    len_nxt        = len_q;
    out_valid_nxt  = 1'b0;
    out_clause_nxt = out_clause_q;
    out_len_nxt    = out_len_q;
    unique case (state)
      ST_IDLE: begin
        if (start_load_i || start_rd_i) begin
          state_nxt = start_load_i ? ST_LOAD : ST_RD_ISSUE;
          cnt_nxt   = (num_clauses_i > MAX_CNT) ? MAX_CNT : num_clauses_i;
          idx_nxt   = '0;
        end
      end
      ST_LOAD: begin
        if (cnt == '0) begin
          state_nxt = ST_DONE;
        end else if (accept_c) begin
          wr_nxt     = NUM_CLAUSES'(1) << idx;
          clause_nxt = bus.in_clause_i;
          len_nxt    = lit_len_c;
          if (is_last_c) begin
            state_nxt = ST_DONE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + WIDTH_IDX'(1);
          end
        end
      end
      ST_RD_ISSUE: begin
        if (cnt == '0) begin
          state_nxt = ST_DONE;
        end else begin
          out_clause_nxt = bus.clause_i;
          out_len_nxt    = row_len_c;
          out_valid_nxt  = 1'b1;
          state_nxt      = ST_RD_HOLD;
        end
      end
      ST_RD_HOLD: begin
        out_valid_nxt = 1'b1;
        if (bus.out_ready_i) begin
          out_valid_nxt = 1'b0;
          if (is_last_c) begin
            state_nxt = ST_DONE;
            idx_nxt   = '0;
          end else begin
            state_nxt = ST_RD_ISSUE;
            idx_nxt   = idx + WIDTH_IDX'(1);
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      cnt          <= '0;
      wr_q         <= '0;
      clause_q     <= '0;
      len_q        <= '0;
      out_valid_q  <= 1'b0;
      out_clause_q <= '0;
      out_len_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      cnt          <= cnt_nxt;
      wr_q         <= wr_nxt;
      clause_q     <= clause_nxt;
      len_q        <= len_nxt;
      out_valid_q  <= out_valid_nxt;
      out_clause_q <= out_clause_nxt;
      out_len_q    <= out_len_nxt;
      busy_q       <= (state_nxt != ST_IDLE);
      done_q       <= (state == ST_DONE);
    end
  end

  // Row select is decoded from registered state so the array answers within the issue cycle.
  assign bus.rd_o         = (state == ST_RD_ISSUE && cnt != '0) ? (NUM_CLAUSES'(1) << idx) : '0;
  assign bus.in_ready_o   = (state == ST_LOAD);
  assign bus.wr_o         = wr_q;
  assign bus.clause_o     = clause_q;
  assign bus.clause_len_o = len_q;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_clause_o = out_clause_q;
  assign bus.out_len_o    = out_len_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

`ifdef CLAUSE_BIN_LOADER_CHECK_EN
  logic err_q;

  // Sticky flag for illegal, empty or saturating beats; the beat is written regardless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == ST_IDLE && start_load_i) begin
      err_q <= 1'b0;
    end else if (accept_c && (lit_bad_c || lit_zero_c || lit_sat_c)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_lit_flags;
  assign unused_lit_flags = lit_bad_c | lit_zero_c | lit_sat_c;
`endif
endmodule

// File: tb/tb_clause_bin_loader.sv
// Self-checking bench for clause_bin_loader: directed scenarios plus randomized
// load/readback rounds against a behavioural model of the clause rows.
module tb_clause_bin_loader;
  import sat_loader_pkg::*;

  localparam int unsigned NV = 8;
  localparam int unsigned NC = 8;
  localparam int unsigned WL = 4;
  localparam int unsigned WI = 4;
  localparam int unsigned CW = NV * 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_load_i = 1'b0;
  logic          start_rd_i = 1'b0;
  logic [WI-1:0] num_clauses_i = '0;
  logic          busy_o, done_o;
`ifdef CLAUSE_BIN_LOADER_CHECK_EN
  logic          err_o;
  bit            exp_err = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  clause_bin_loader_if #(.NUM_VARS(NV), .NUM_CLAUSES(NC), .WIDTH_C_LEN(WL)) bus ();

  clause_bin_loader #(.NUM_VARS(NV), .NUM_CLAUSES(NC), .WIDTH_C_LEN(WL), .WIDTH_IDX(WI)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_load_i  (start_load_i),
    .start_rd_i    (start_rd_i),
    .num_clauses_i (num_clauses_i),
    .bus           (bus.master),
    .busy_o        (busy_o),
    .done_o        (done_o)
`ifdef CLAUSE_BIN_LOADER_CHECK_EN
    ,
    .err_o         (err_o)
`endif
  );

  always #5 clk = ~clk;

  // Clause array rows: written by wr_o, OR-ed onto clause_i by rd_o.
  logic [CW-1:0] mem [NC];
  logic [WL-1:0] mem_len [NC];

  always @(posedge clk) begin
    for (int r = 0; r < int'(NC); r++) begin
      if (bus.wr_o[r]) begin
        mem[r]     <= bus.clause_o;
        mem_len[r] <= bus.clause_len_o;
      end
    end
  end

  always_comb begin
    logic [CW-1:0] acc;
    acc = '0;
    for (int r = 0; r < int'(NC); r++) begin
      if (bus.rd_o[r]) acc = acc | mem[r];
    end
    bus.clause_i = acc;
  end

  always_comb begin
    for (int r = 0; r < int'(NC); r++) bus.clause_len_i[r*WL +: WL] = mem_len[r];
  end

  // Reference: what each row must hold, and the last value on the write bus.
  logic [CW-1:0] ref_clause [NC];
  int            ref_len [NC];
  logic [CW-1:0] stim [NC];
  logic [CW-1:0] last_clause = '0;
  int            last_len = 0;

  function automatic int model_len(input logic [CW-1:0] c);
    int n;
    logic [1:0] f;
    n = 0;
    for (int i = 0; i < int'(NV); i++) begin
      f = c[2*i +: 2];
      if (f == LIT_POS || f == LIT_NEG || f == LIT_BAD) n++;
    end
    return (n > 15) ? 15 : n;
  endfunction

  function automatic bit model_err(input logic [CW-1:0] c);
    int n;
    bit bad;
    n = 0;
    bad = 1'b0;
    for (int i = 0; i < int'(NV); i++) begin
      if (c[2*i +: 2] != LIT_NONE) n++;
      if (c[2*i +: 2] == LIT_BAD) bad = 1'b1;
    end
    return bad || (n == 0) || (n > 15);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_err(input string tag);
`ifdef CLAUSE_BIN_LOADER_CHECK_EN
    chk(tag, 32'(err_o), 32'(exp_err));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_run(input int n, input int mode);
    int eff, k, cyc;
    bit v;
    eff = (n > int'(NC)) ? int'(NC) : n;
    start_load_i = 1'b1;
    num_clauses_i = WI'(n);
    tick();
    start_load_i = 1'b0;
`ifdef CLAUSE_BIN_LOADER_CHECK_EN
    exp_err = 1'b0;
`endif
    chk("ld_busy", 32'(busy_o), 32'd1);
    chk_err("ld_err_clr");
    k = 0;
    cyc = 0;
    if (eff == 0) begin
      chk("ld0_ready", 32'(bus.in_ready_o), 32'd1);
      bus.in_valid_i = 1'($urandom_range(0, 1));
      tick();
      chk("ld0_wr", 32'(bus.wr_o), 32'd0);
    end
    while (k < eff) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 1) : ((($urandom % 2) == 1) || cyc > 40);
      bus.in_valid_i = v;
      bus.in_clause_i = v ? stim[k] : CW'($urandom);
      start_rd_i = (($urandom % 4) == 0);
      chk("ld_ready", 32'(bus.in_ready_o), 32'd1);
      tick();
      start_rd_i = 1'b0;
      if (v) begin
        ref_clause[k] = stim[k];
        ref_len[k] = model_len(stim[k]);
        last_clause = stim[k];
        last_len = ref_len[k];
`ifdef CLAUSE_BIN_LOADER_CHECK_EN
        exp_err = exp_err | model_err(stim[k]);
`endif
        chk("ld_wr", 32'(bus.wr_o), 32'd1 << k);
        k++;
      end else begin
        chk("ld_wr_gap", 32'(bus.wr_o), 32'd0);
      end
      chk("ld_clause", 32'(bus.clause_o), 32'(last_clause));
      chk("ld_len", 32'(bus.clause_len_o), 32'(last_len));
      chk("ld_rd", 32'(bus.rd_o), 32'd0);
      chk_err("ld_err");
      cyc++;
    end
    bus.in_valid_i = 1'b0;
    chk("ld_done_lag", 32'(done_o), 32'd0);
    chk("ld_busy_done", 32'(busy_o), 32'd1);
    chk("ld_ready_done", 32'(bus.in_ready_o), 32'd0);
    tick();
    chk("ld_done", 32'(done_o), 32'd1);
    chk("ld_idle_busy", 32'(busy_o), 32'd0);
    chk("ld_idle_wr", 32'(bus.wr_o), 32'd0);
    chk_err("ld_err_end");
    tick();
    chk("ld_done_pulse", 32'(done_o), 32'd0);
  endtask

  task automatic rd_run(input int n, input int max_stall);
    int eff, k, s;
    eff = (n > int'(NC)) ? int'(NC) : n;
    start_rd_i = 1'b1;
    num_clauses_i = WI'(n);
    tick();
    start_rd_i = 1'b0;
    chk("rd_busy", 32'(busy_o), 32'd1);
    k = 0;
    if (eff == 0) begin
      chk("rd0_sel", 32'(bus.rd_o), 32'd0);
      tick();
      chk("rd0_sel2", 32'(bus.rd_o), 32'd0);
    end
    while (k < eff) begin
      chk("rd_sel", 32'(bus.rd_o), 32'd1 << k);
      chk("rd_issue_valid", 32'(bus.out_valid_o), 32'd0);
      start_load_i = (($urandom % 4) == 0);
      bus.out_ready_i = 1'b0;
      tick();
      start_load_i = 1'b0;
      s = (max_stall < 0) ? ((k == 0) ? 5 : 0) : $urandom_range(0, max_stall);
      for (int j = 0; j <= s; j++) begin
        chk("rd_valid", 32'(bus.out_valid_o), 32'd1);
        chk("rd_hold_sel", 32'(bus.rd_o), 32'd0);
        chk("rd_clause", 32'(bus.out_clause_o), 32'(ref_clause[k]));
        chk("rd_len", 32'(bus.out_len_o), 32'(ref_len[k]));
        bus.out_ready_i = (j == s);
        tick();
      end
      bus.out_ready_i = 1'b0;
      k++;
    end
    chk("rd_valid_end", 32'(bus.out_valid_o), 32'd0);
    chk("rd_done_lag", 32'(done_o), 32'd0);
    tick();
    chk("rd_done", 32'(done_o), 32'd1);
    chk("rd_idle_busy", 32'(busy_o), 32'd0);
    chk_err("rd_err");
    tick();
  endtask

  initial begin
    bus.in_valid_i = 1'b0;
    bus.in_clause_i = '0;
    bus.out_ready_i = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.in_ready_o), 32'd0);
    chk("rst_wr", 32'(bus.wr_o), 32'd0);
    chk("rst_rd", 32'(bus.rd_o), 32'd0);
    chk("rst_clause", 32'(bus.clause_o), 32'd0);
    chk("rst_len", 32'(bus.clause_len_o), 32'd0);
    chk("rst_ovalid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_oclause", 32'(bus.out_clause_o), 32'd0);
    chk("rst_olen", 32'(bus.out_len_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk_err("rst_err");
    rst = 1'b0;
    tick();

    // Three clauses back to back: lengths 2, 8, 1.
    stim[0] = 16'b00_00_00_00_00_00_10_01;
    stim[1] = 16'b01_01_01_01_01_01_01_01;
    stim[2] = 16'b00_00_00_00_00_00_00_10;
    load_run(3, 0);

    // Full array with valid toggling every other cycle.
    for (int i = 0; i < int'(NC); i++) stim[i] = CW'($urandom);
    load_run(8, 1);

    // Readback with a long stall on row 0, which holds an empty clause.
    stim[0] = '0;
    stim[1] = 16'b10_00_01_00_00_00_01_00;
    load_run(2, 0);
    rd_run(2, -1);

    // Simultaneous starts with a zero count: load wins, nothing is strobed.
    start_load_i = 1'b1;
    start_rd_i = 1'b1;
    num_clauses_i = '0;
    tick();
    start_load_i = 1'b0;
    start_rd_i = 1'b0;
`ifdef CLAUSE_BIN_LOADER_CHECK_EN
    exp_err = 1'b0;
`endif
    chk("both_ready", 32'(bus.in_ready_o), 32'd1);
    chk("both_rd", 32'(bus.rd_o), 32'd0);
    tick();
    chk("both_wr", 32'(bus.wr_o), 32'd0);
    chk("both_rd2", 32'(bus.rd_o), 32'd0);
    chk("both_done_lag", 32'(done_o), 32'd0);
    tick();
    chk("both_done", 32'(done_o), 32'd1);
    chk("both_busy", 32'(busy_o), 32'd0);
    tick();

    // Asynchronous reset after two accepted beats.
    start_load_i = 1'b1;
    num_clauses_i = WI'(5);
    tick();
    start_load_i = 1'b0;
    bus.in_valid_i = 1'b1;
    for (int b = 0; b < 2; b++) begin
      stim[b] = CW'($urandom) | 16'h0001;
      bus.in_clause_i = stim[b];
      tick();
      ref_clause[b] = stim[b];
      ref_len[b] = model_len(stim[b]);
      chk("pre_rst_wr", 32'(bus.wr_o), 32'd1 << b);
    end
    bus.in_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_wr", 32'(bus.wr_o), 32'd0);
    chk("arst_clause", 32'(bus.clause_o), 32'd0);
    chk("arst_len", 32'(bus.clause_len_o), 32'd0);
    chk("arst_ready", 32'(bus.in_ready_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_done", 32'(done_o), 32'd0);
    last_clause = '0;
    last_len = 0;
`ifdef CLAUSE_BIN_LOADER_CHECK_EN
    exp_err = 1'b0;
`endif
    chk_err("arst_err");
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) stim[i] = CW'($urandom);
    load_run(3, 2);

`ifdef CLAUSE_BIN_LOADER_CHECK_EN
    // Illegal code is still written, counts as a literal and sets the sticky flag.
    stim[0] = 16'b00_00_00_00_00_00_01_11;
    load_run(1, 0);
    chk("chk_len", 32'(bus.clause_len_o), 32'd2);
    chk("chk_err_set", 32'(err_o), 32'd1);
    rd_run(1, 2);
    chk("chk_err_hold", 32'(err_o), 32'd1);
    stim[0] = 16'b00_00_00_00_00_00_01_10;
    load_run(1, 0);
    chk("chk_err_cleared", 32'(err_o), 32'd0);
`endif

    // Randomized rounds, including clamped and zero counts.
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < int'(NC); i++) begin
        stim[i] = (($urandom % 5) == 0) ? '0 : CW'($urandom);
      end
      load_run($urandom_range(0, 15), $urandom_range(0, 2));
      rd_run($urandom_range(0, 15), 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
